set_circle_counter: RTL and testbench

//  Counts the lattice points of an 8x8 grid (x,y in 1..8) lying inside up to three

---
 rtl/set_circle_counter.sv | 155 +++++++++++++++
 tb/tb_set_circle_counter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/set_circle_counter.sv
// set_circle_counter
// Sequentially walks the 8x8 lattice (x,y in 1..8), tests every point against
// up to three circles A, B, C, and counts the points whose membership pattern
// matches the requested set operation. One job per en pulse, one point per cycle.
module set_circle_counter (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic        en,
    input  logic [23:0] central,    // {xA,yA,xB,yB,xC,yC}
    input  logic [11:0] radius,     // {rA,rB,rC}
    input  logic [1:0]  mode,
    output logic        busy,
    output logic        valid,
    output logic [7:0]  candidate
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_A        = 2'b00;
    localparam logic [1:0] MODE_A_AND_B  = 2'b01;
    localparam logic [1:0] MODE_A_XOR_B  = 2'b10;
    localparam logic [1:0] MODE_EXACT_2  = 2'b11;

    localparam logic [3:0] GRID_FIRST = 4'd1;
    localparam logic [3:0] GRID_LAST  = 4'd8;

    state_t      state;
    logic [23:0] central_q;
    logic [11:0] radius_q;
    logic [1:0]  mode_q;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [7:0]  count;

    logic        in_a;
    logic        in_b;
    logic        in_c;
    logic        hit;

    // Point (px,py) lies inside circle (cx,cy,r) when the squared distance does
    // not exceed r^2. Differences are signed 5-bit (-14..8 here), squares are
    // taken on the magnitude so the 9-bit sum never wraps.
    function automatic logic in_circle(
        input logic [3:0] px,
        input logic [3:0] py,
        input logic [3:0] cx,
        input logic [3:0] cy,
        input logic [3:0] r
    );
        logic signed [4:0] dx;
        logic signed [4:0] dy;
        logic [3:0]        ax;
        logic [3:0]        ay;
        logic [7:0]        sx;
        logic [7:0]        sy;
        logic [8:0]        d2;
        logic [7:0]        r2;
        dx = $signed({1'b0, px}) - $signed({1'b0, cx});
        dy = $signed({1'b0, py}) - $signed({1'b0, cy});
        ax = dx[4] ? 4'(-dx) : dx[3:0];
        ay = dy[4] ? 4'(-dy) : dy[3:0];
        sx = ax * ax;
        sy = ay * ay;
        d2 = {1'b0, sx} + {1'b0, sy};
        r2 = r * r;
        return (d2 <= {1'b0, r2});
    endfunction

    // Membership of the current grid point in each circle and the mode combine.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        hit  = 1'b0;
        in_a = in_circle(x, y, central_q[23:20], central_q[19:16], radius_q[11:8]);
        in_b = in_circle(x, y, central_q[15:12], central_q[11:8],  radius_q[7:4]);
        in_c = in_circle(x, y, central_q[7:4],   central_q[3:0],   radius_q[3:0]);
        case (mode_q)
            MODE_A:       hit = in_a;
            MODE_A_AND_B: hit = in_a & in_b;
            MODE_A_XOR_B: hit = in_a ^ in_b;
            MODE_EXACT_2: hit = (in_a & in_b & ~in_c) |
                                (in_a & ~in_b & in_c) |
                                (~in_a & in_b & in_c);
            default:      hit = 1'b0;
        endcase
    end

    // Job FSM: accept, scan 64 points, publish the count, return to idle.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: all state, including the captured job fields, is cleared on
        // reset so an aborted job leaves nothing behind.
        if (!rst) begin
            state     <= IDLE;
            central_q <= '0;
            radius_q  <= '0;
            mode_q    <= '0;
            x         <= GRID_FIRST;
            y         <= GRID_FIRST;
            count     <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            candidate <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register sees the pre-edge values of its neighbours.
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    if (busy) begin
                        // First idle cycle after DONE: busy still covers the
                        // cycle in which valid is shown, so en is not yet taken.
                        busy <= 1'b0;
                    end else if (en) begin
                        central_q <= central;
                        radius_q  <= radius;
                        mode_q    <= mode;
                        count     <= '0;
                        x         <= GRID_FIRST;
                        y         <= GRID_FIRST;
                        busy      <= 1'b1;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    count <= count + {7'd0, hit};
                    if (x == GRID_LAST) begin
                        x <= GRID_FIRST;
                        if (y == GRID_LAST) begin
                            state <= DONE;
                        end else begin
                            y <= y + 4'd1;
                        end
                    end else begin
                        x <= x + 4'd1;
                    end
                end
                DONE: begin
                    candidate <= count;
                    valid     <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_set_circle_counter.sv
// tb_set_circle_counter
// Directed jobs with hand-computed counts. A driver issues jobs and pushes the
// expected count plus issue cycle; a monitor pops on every valid strobe.
module tb_set_circle_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [23:0] central = '0;
    logic [11:0] radius = '0;
    logic [1:0]  mode = '0;
    logic        busy;
    logic        valid;
    logic [7:0]  candidate;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    localparam int NV = 13;
    localparam int LATENCY = 66;

    typedef struct {
        logic [23:0] c;
        logic [11:0] r;
        logic [1:0]  m;
        logic [7:0]  e;
    } vec_t;

    typedef struct {
        logic [7:0] e;
        int         issue;
        int         id;
    } exp_t;

    exp_t q[$];

    set_circle_counter dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .central   (central),
        .radius    (radius),
        .mode      (mode),
        .busy      (busy),
        .valid     (valid),
        .candidate (candidate)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] xa, ya, xb, yb, xc, yc,
                                input logic [3:0] ra, rb, rc,
                                input logic [1:0] m, input logic [7:0] e);
        vec_t v;
        v.c = {xa, ya, xb, yb, xc, yc};
        v.r = {ra, rb, rc};
        v.m = m;
        v.e = e;
        return v;
    endfunction

    function automatic vec_t vec(input int i);
        case (i)
            0:  return mk(4, 4, 1, 1, 0, 0,  1, 15, 0,  2'b00, 8'd5);
            1:  return mk(4, 4, 0, 0, 0, 0, 15,  0, 0,  2'b00, 8'd64);
            2:  return mk(0, 0, 0, 0, 0, 0,  0,  0, 0,  2'b00, 8'd0);
            3:  return mk(4, 4, 5, 4, 0, 0,  1,  1, 0,  2'b01, 8'd2);
            4:  return mk(4, 4, 5, 4, 0, 0,  1,  1, 0,  2'b10, 8'd6);
            5:  return mk(4, 4, 5, 4, 8, 8,  1,  1, 0,  2'b11, 8'd2);
            6:  return mk(4, 4, 5, 4, 4, 4,  1,  1, 0,  2'b11, 8'd1);
            7:  return mk(0, 0, 0, 0, 0, 0,  3,  0, 0,  2'b00, 8'd4);
            8:  return mk(8, 8, 0, 0, 0, 0,  1,  0, 0,  2'b00, 8'd3);
            9:  return mk(4, 4, 4, 4, 0, 0,  0,  1, 0,  2'b10, 8'd4);
            10: return mk(4, 4, 8, 8, 0, 0, 15,  0, 0,  2'b01, 8'd1);
            11: return mk(4, 4, 4, 4, 4, 4, 15, 15, 15, 2'b11, 8'd0);
            default: return mk(4, 4, 5, 4, 4, 4, 1, 1, 15, 2'b11, 8'd6);
        endcase
    endfunction

    // Waits (bounded) for an idle DUT, issues job i and records the expectation.
    task automatic run_job(input int i);
        vec_t v;
        exp_t x;
        int   n;
        v = vec(i);
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("busy_wait_timeout", busy, 0);
        central = v.c;
        radius  = v.r;
        mode    = v.m;
        en      = 1'b1;
        x.e     = v.e;
        x.issue = cyc;
        x.id    = i;
        q.push_back(x);
        @(negedge clk);
        en = 1'b0;
        central = '0;
        radius  = '0;
        mode    = '0;
        check("busy_after_accept", busy, 1);
    endtask

    // Pulses en with a different job while busy; it must have no effect.
    task automatic poke_while_busy();
        vec_t v;
        v = vec(1);
        repeat (10) @(negedge clk);
        central = v.c;
        radius  = v.r;
        mode    = v.m;
        en      = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    // Monitor: every valid strobe pops one expectation and checks it.
    initial begin
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (valid) begin
                check("valid_one_cycle", prev_valid, 0);
                check("busy_during_valid", busy, 1);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: candidate %0d with no job pending", candidate);
                end else begin
                    e = q.pop_front();
                    check($sformatf("candidate_vec%0d", e.id), candidate, e.e);
                    check($sformatf("latency_vec%0d", e.id), cyc - e.issue, LATENCY);
                end
            end else if (prev_valid) begin
                check("busy_falls_after_valid", busy, 0);
            end
            prev_valid = valid;
        end
    end

    initial begin
        int n;
        #3;
        check("reset_busy", busy, 0);
        check("reset_valid", valid, 0);
        check("reset_candidate", candidate, 0);
        @(negedge clk);
        rst = 1'b1;

        // Directed vectors, with an ignored en pulse during one job.
        for (int i = 0; i < NV; i++) begin
            run_job(i);
            if (i == 3) poke_while_busy();
        end

        // Back-to-back jobs cycling through the table.
        for (int k = 0; k < 64; k++) run_job(k % NV);

        // Mid-job reset aborts; the held 64 must clear asynchronously.
        run_job(1);
        run_job(8);
        repeat (20) @(negedge clk);
        check("candidate_before_abort", candidate, 64);
        #2;
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", valid, 0);
        check("abort_candidate", candidate, 0);
        q.delete();
        repeat (3) @(negedge clk);
        check("abort_no_result", valid, 0);
        rst = 1'b1;
        run_job(0);
        run_job(4);

        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", q.size(), 0);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
